// File: rtl/as2650_bus_pkg.sv
// rtl/as2650_bus_pkg.sv - shared types and parameter limits for the AS2650 bus sequencer
package as2650_bus_pkg;

  // Request space selected by the core.
  typedef enum logic [1:0] {
    BT_MEM = 2'd0,
    BT_IOC = 2'd1,
    BT_IOD = 2'd2,
    BT_IOE = 2'd3
  } bt_e;

  // Bus-cycle phases. ST_RESP is the single rsp_valid cycle that separates
  // HOLD from IDLE, so a new request can never be accepted alongside a response.
  typedef enum logic [3:0] {
    ST_IDLE  = 4'd0,
    ST_AHI   = 4'd1,
    ST_AGAP  = 4'd2,
    ST_ALO   = 4'd3,
    ST_AGAP2 = 4'd4,
    ST_DATA  = 4'd5,
    ST_WAIT  = 4'd6,
    ST_HOLD  = 4'd7,
    ST_RESP  = 4'd8
  } state_e;

  localparam int ADDR_W_MIN      = 9;
  localparam int ADDR_W_MAX      = 16;
  localparam int WAIT_STATES_MAX = 7;
  localparam int READY_TO_MIN    = 1;
  localparam int READY_TO_MAX    = 255;

  // True when every parameter lies inside the range the counters and muxes are sized for.
  function automatic bit params_ok(input int addr_w, input int wait_states,
                                   input int ready_to, input int hi_cache);
    return (addr_w >= ADDR_W_MIN) && (addr_w <= ADDR_W_MAX) &&
           (wait_states >= 0) && (wait_states <= WAIT_STATES_MAX) &&
           (ready_to >= READY_TO_MIN) && (ready_to <= READY_TO_MAX) &&
           ((hi_cache == 0) || (hi_cache == 1));
  endfunction

endpackage

// File: rtl/as2650_wait_ctr.sv
// rtl/as2650_wait_ctr.sv - wait-state preload followed by a READY timeout down-counter
module as2650_wait_ctr #(
  parameter int WAIT_STATES = 0,
  parameter int READY_TO    = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic ready_i,
  output logic done,
  output logic timeout
);

  localparam logic [2:0] WS_INIT = 3'(WAIT_STATES);
  localparam logic [7:0] TO_INIT = 8'(READY_TO);

  logic [2:0] ws_q, ws_d;
  logic [7:0] to_q, to_d;

  // Counters sit preloaded while the strobe is inactive; during the strobe the
  // wait states drain first, then every cycle with ready_i low burns one timeout tick.
  always_comb begin
    ws_d    = ws_q;
    to_d    = to_q;
    done    = en && (ws_q == 3'd0) && ready_i;
    timeout = en && (ws_q == 3'd0) && !ready_i && (to_q <= 8'd1);
    if (!en) begin
      ws_d = WS_INIT;
      to_d = TO_INIT;
    end else if (ws_q != 3'd0) begin
      ws_d = ws_q - 3'd1;
    end else if (!ready_i && (to_q > 8'd1)) begin
      to_d = to_q - 8'd1;
    end
  end

  // Counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ws_q <= WS_INIT;
      to_q <= TO_INIT;
    end else begin
      ws_q <= ws_d;
      to_q <= to_d;
    end
  end

endmodule

// File: rtl/as2650_bus_seq.sv
// rtl/as2650_bus_seq.sv - AS2650 multiplexed external bus-cycle sequencer
module as2650_bus_seq
  import as2650_bus_pkg::*;
#(
  parameter int ADDR_W      = 16,
  parameter int WAIT_STATES = 0,
  parameter int READY_TO    = 15,
  parameter int HI_CACHE    = 1
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_type,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [7:0]        req_wdata,
  output logic              rsp_valid,
  output logic [7:0]        rsp_rdata,
  output logic              rsp_err,
  input  logic              hi_flush,
  input  logic [7:0]        bus_in,
  output logic [7:0]        bus_out,
  output logic              bus_oe,
  output logic              le_hi,
  output logic              le_lo,
  output logic              oe_n,
  output logic              we_n,
  output logic              ioc,
  output logic              iod,
  output logic              ioe,
  input  logic              ready_i
);

  if (!params_ok(ADDR_W, WAIT_STATES, READY_TO, HI_CACHE)) begin : g_param_err
    $error("as2650_bus_seq: parameter out of range");
  end

  state_e            state_q, state_d;
  bt_e               type_q, type_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        wdata_q, wdata_d;
  logic [7:0]        rdata_q, rdata_d;
  logic              err_q, err_d;
  logic [7:0]        hi_q, hi_d;
  logic              hi_valid_q, hi_valid_d;

  logic [7:0] req_hi;
  logic [7:0] cur_hi;
  logic       skip_hi;
  logic       accept;
  logic       strobe;
  logic       io_sel;
  logic       wait_done;
  logic       wait_timeout;

  // High address byte, zero-padded when ADDR_W < 16, for both the incoming and the latched request.
  always_comb begin
    req_hi = '0;
    req_hi[ADDR_W-9:0] = req_addr[ADDR_W-1:8];
    cur_hi = '0;
    cur_hi[ADDR_W-9:0] = addr_q[ADDR_W-1:8];
  end

  assign req_ready = (state_q == ST_IDLE) && !wb_rst_i;
  assign accept    = req_valid && req_ready;
  // A flush in the decision cycle wins over a cache hit so the external latch is refreshed.
  assign skip_hi   = (HI_CACHE != 0) && hi_valid_q && !hi_flush && (req_hi == hi_q);
  assign strobe    = (state_q == ST_DATA) || (state_q == ST_WAIT);

  as2650_wait_ctr #(
    .WAIT_STATES (WAIT_STATES),
    .READY_TO    (READY_TO)
  ) u_wait_ctr (
    .clk     (wb_clk_i),
    .rst     (wb_rst_i),
    .en      (strobe),
    .ready_i (ready_i),
    .done    (wait_done),
    .timeout (wait_timeout)
  );

  // Next state, request latch, read capture and high-byte cache maintenance.
  always_comb begin
    state_d    = state_q;
    type_d     = type_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    hi_d       = hi_q;
    hi_valid_d = hi_valid_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          type_d  = bt_e'(req_type);
          we_d    = req_we;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          case (bt_e'(req_type))
            BT_IOC, BT_IOD: state_d = ST_DATA;
            BT_IOE:         state_d = ST_ALO;
            default:        state_d = skip_hi ? ST_ALO : ST_AHI;
          endcase
        end
      end
      ST_AHI: begin
        state_d    = ST_AGAP;
        hi_d       = cur_hi;
        hi_valid_d = 1'b1;
      end
      ST_AGAP:  state_d = ST_ALO;
      ST_ALO:   state_d = ST_AGAP2;
      ST_AGAP2: state_d = ST_DATA;
      ST_DATA, ST_WAIT: begin
        if (wait_done || wait_timeout) begin
          state_d = ST_HOLD;
          err_d   = wait_timeout;
          rdata_d = (we_q || wait_timeout) ? 8'h00 : bus_in;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_HOLD:  state_d = ST_RESP;
      ST_RESP:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    // A timed-out device may have missed the latch, so the cached byte is no longer trusted.
    if (hi_flush || wait_timeout) begin
      hi_valid_d = 1'b0;
    end
  end

  // State and request registers; reset drops everything mid-cycle and loses any request in flight.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q    <= ST_IDLE;
      type_q     <= BT_MEM;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= 8'h00;
      rdata_q    <= 8'h00;
      err_q      <= 1'b0;
      hi_q       <= 8'h00;
      hi_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      type_q     <= type_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
      hi_q       <= hi_d;
      hi_valid_q <= hi_valid_d;
    end
  end

  // Pin decode from the current phase; gaps keep the bus driven for latch hold time.
  always_comb begin
    le_hi   = 1'b0;
    le_lo   = 1'b0;
    oe_n    = 1'b1;
    we_n    = 1'b1;
    bus_oe  = 1'b0;
    bus_out = 8'h00;
    io_sel  = 1'b0;
    case (state_q)
      ST_AHI: begin
        le_hi   = 1'b1;
        bus_oe  = 1'b1;
        bus_out = cur_hi;
      end
      ST_AGAP: begin
        bus_oe  = 1'b1;
        bus_out = cur_hi;
      end
      ST_ALO: begin
        le_lo   = 1'b1;
        bus_oe  = 1'b1;
        bus_out = addr_q[7:0];
      end
      ST_AGAP2: begin
        // Reads release the pads here so the device can drive in the strobe cycle.
        bus_oe  = we_q;
        bus_out = addr_q[7:0];
      end
      ST_DATA, ST_WAIT: begin
        io_sel = 1'b1;
        if (we_q) begin
          we_n    = 1'b0;
          bus_oe  = 1'b1;
          bus_out = wdata_q;
        end else begin
          oe_n = 1'b0;
        end
      end
      ST_HOLD: begin
        io_sel = 1'b1;
        if (we_q) begin
          bus_oe  = 1'b1;
          bus_out = wdata_q;
        end
      end
      default: ;
    endcase
    ioc = io_sel && (type_q == BT_IOC);
    iod = io_sel && (type_q == BT_IOD);
    ioe = io_sel && (type_q == BT_IOE);
  end

  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_err   = (state_q == ST_RESP) && err_q;
  assign rsp_rdata = rdata_q;

endmodule

// File: tb/tb_as2650_bus_seq.sv
// tb/tb_as2650_bus_seq.sv - directed self-checking bench for as2650_bus_seq
module tb_as2650_bus_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        rv_a, rv_b;
  logic [1:0]  req_type;
  logic        req_we;
  logic [15:0] req_addr;
  logic [7:0]  req_wdata;
  logic        hi_flush;
  logic [7:0]  bus_in;
  logic        ready_i;

  logic        rr_a, rsp_valid_a, rsp_err_a, bus_oe_a, le_hi_a, le_lo_a, oe_n_a, we_n_a, ioc_a, iod_a, ioe_a;
  logic [7:0]  rsp_rdata_a, bus_out_a;
  logic        rr_b, rsp_valid_b, rsp_err_b, bus_oe_b, le_hi_b, le_lo_b, oe_n_b, we_n_b, ioc_b, iod_b, ioe_b;
  logic [7:0]  rsp_rdata_b, bus_out_b;

  logic [15:0] vec_a, vec_b;
  assign vec_a = {le_hi_a, le_lo_a, oe_n_a, we_n_a, ioc_a, iod_a, ioe_a, bus_oe_a, bus_out_a};
  assign vec_b = {le_hi_b, le_lo_b, oe_n_b, we_n_b, ioc_b, iod_b, ioe_b, bus_oe_b, bus_out_b};

  as2650_bus_seq dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .req_valid(rv_a), .req_ready(rr_a),
    .req_type(req_type), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid_a), .rsp_rdata(rsp_rdata_a), .rsp_err(rsp_err_a),
    .hi_flush(hi_flush), .bus_in(bus_in), .bus_out(bus_out_a), .bus_oe(bus_oe_a),
    .le_hi(le_hi_a), .le_lo(le_lo_a), .oe_n(oe_n_a), .we_n(we_n_a),
    .ioc(ioc_a), .iod(iod_a), .ioe(ioe_a), .ready_i(ready_i)
  );

  as2650_bus_seq #(.WAIT_STATES(2), .READY_TO(5)) dut_ws (
    .wb_clk_i(clk), .wb_rst_i(rst), .req_valid(rv_b), .req_ready(rr_b),
    .req_type(req_type), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid_b), .rsp_rdata(rsp_rdata_b), .rsp_err(rsp_err_b),
    .hi_flush(hi_flush), .bus_in(bus_in), .bus_out(bus_out_b), .bus_oe(bus_oe_b),
    .le_hi(le_hi_b), .le_lo(le_lo_b), .oe_n(oe_n_b), .we_n(we_n_b),
    .ioc(ioc_b), .iod(iod_b), .ioe(ioe_b), .ready_i(ready_i)
  );

  int          checks = 0;
  int          failures = 0;
  logic [15:0] tr [0:47];
  int          n;
  logic [7:0]  got_rdata;
  logic        got_err;
  logic        rr_at_rsp;
  logic [15:0] e7 [0:6];

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int count_bit(input int b, input logic v);
    int k = 0;
    for (int c = 1; c <= n; c++) if (tr[c][b] === v) k++;
    return k;
  endfunction

  // Issue one request, record the pin vector each cycle until rsp_valid, then return to IDLE.
  task automatic do_req(input bit inst, input logic [1:0] t, input logic we, input logic [15:0] a,
                        input logic [7:0] wd, input bit flush, input int rlo_from, input int rlo_to);
    int w;
    bit seen;
    req_type = t; req_we = we; req_addr = a; req_wdata = wd; hi_flush = flush;
    if (inst) rv_b = 1'b1; else rv_a = 1'b1;
    w = 0;
    while (((inst ? rr_b : rr_a) !== 1'b1) && (w < 20)) begin
      tick();
      w++;
    end
    chk("accept_in_time", {15'h0, (w < 20)}, 16'h0001);
    tick();
    rv_a = 1'b0; rv_b = 1'b0; hi_flush = 1'b0;
    req_type = 2'($urandom); req_we = 1'($urandom); req_addr = 16'($urandom); req_wdata = 8'($urandom);
    n = 0; seen = 1'b0;
    for (int c = 1; c < 48; c++) begin
      if (!seen) begin
        ready_i = !((c >= rlo_from) && (c <= rlo_to));
        tr[c] = inst ? vec_b : vec_a;
        if ((inst ? rsp_valid_b : rsp_valid_a) === 1'b1) begin
          seen = 1'b1;
          n = c;
          got_rdata = inst ? rsp_rdata_b : rsp_rdata_a;
          got_err = inst ? rsp_err_b : rsp_err_a;
          rr_at_rsp = inst ? rr_b : rr_a;
        end else begin
          tick();
        end
      end
    end
    ready_i = 1'b1;
    tick();
    chk("rsp_one_cycle", {15'h0, (inst ? rsp_valid_b : rsp_valid_a)}, 16'h0000);
  endtask

  initial begin
    int rsp_cnt;
    rst = 1'b1; rv_a = 1'b0; rv_b = 1'b0; req_type = 2'd0; req_we = 1'b0; req_addr = 16'h0;
    req_wdata = 8'h0; hi_flush = 1'b0; bus_in = 8'h00; ready_i = 1'b1;
    repeat (3) tick();
    chk("rst_pins", vec_a, 16'h3000);
    chk("rst_rsp", {6'h0, rsp_valid_a, rsp_err_a, rsp_rdata_a}, 16'h0000);
    chk("rst_req_ready", {15'h0, rr_a}, 16'h0000);
    rst = 1'b0;
    tick();
    chk("idle_req_ready", {15'h0, rr_a}, 16'h0001);

    // T1: MEM read 0x0000, full seven-cycle sequence
    bus_in = 8'h5A;
    do_req(1'b0, 2'd0, 1'b0, 16'h0000, 8'h00, 1'b0, 0, -1);
    chk("t1_latency", 16'(n), 16'd7);
    e7 = '{16'hB100, 16'h3100, 16'h7100, 16'h3000, 16'h1000, 16'h3000, 16'h3000};
    for (int c = 1; c <= 7; c++) chk($sformatf("t1_cycle%0d", c), tr[c], e7[c-1]);
    chk("t1_rdata", {8'h0, got_rdata}, 16'h005A);
    chk("t1_err", {15'h0, got_err}, 16'h0000);
    chk("t1_no_ready_at_rsp", {15'h0, rr_at_rsp}, 16'h0000);

    // T2: high-byte cache hit, explicit flush, flush at the decision cycle
    bus_in = 8'hC3;
    do_req(1'b0, 2'd0, 1'b0, 16'h1234, 8'h00, 1'b0, 0, -1);
    chk("t2a_latency", 16'(n), 16'd7);
    chk("t2a_hi_phase", tr[1], 16'hB112);
    chk("t2a_lo_phase", tr[3], 16'h7134);
    chk("t2a_turnaround", tr[4], 16'h3034);
    chk("t2a_rdata", {8'h0, got_rdata}, 16'h00C3);
    do_req(1'b0, 2'd0, 1'b0, 16'h1235, 8'h00, 1'b0, 0, -1);
    chk("t2b_latency", 16'(n), 16'd5);
    chk("t2b_lo_first", tr[1], 16'h7135);
    chk("t2b_no_le_hi", 16'(count_bit(15, 1'b1)), 16'd0);
    hi_flush = 1'b1;
    tick();
    hi_flush = 1'b0;
    do_req(1'b0, 2'd0, 1'b0, 16'h1236, 8'h00, 1'b0, 0, -1);
    chk("t2c_flush_latency", 16'(n), 16'd7);
    chk("t2c_flush_hi_phase", tr[1], 16'hB112);
    do_req(1'b0, 2'd0, 1'b0, 16'h1237, 8'h00, 1'b1, 0, -1);
    chk("t2d_flush_at_decision", 16'(n), 16'd7);

    // T3: IOC write 0x0A
    bus_in = 8'hFF;
    do_req(1'b0, 2'd1, 1'b1, 16'h0000, 8'h0A, 1'b0, 0, -1);
    chk("t3_latency", 16'(n), 16'd3);
    chk("t3_strobe", tr[1], 16'h290A);
    chk("t3_hold", tr[2], 16'h390A);
    chk("t3_release", tr[3], 16'h3000);
    chk("t3_no_le", 16'(count_bit(15, 1'b1) + count_bit(14, 1'b1)), 16'd0);
    chk("t3_write_rdata", {8'h0, got_rdata}, 16'h0000);

    // T4: IOD read 0x89, IOE write to port 0x42, MEM cache untouched by I/O
    bus_in = 8'h89;
    do_req(1'b0, 2'd2, 1'b0, 16'h0000, 8'h00, 1'b0, 0, -1);
    chk("t4a_latency", 16'(n), 16'd3);
    chk("t4a_strobe", tr[1], 16'h1400);
    chk("t4a_hold", tr[2], 16'h3400);
    chk("t4a_iod_cycles", 16'(count_bit(10, 1'b1)), 16'd2);
    chk("t4a_rdata", {8'h0, got_rdata}, 16'h0089);
    do_req(1'b0, 2'd3, 1'b1, 16'hAB42, 8'h77, 1'b0, 0, -1);
    chk("t4b_latency", 16'(n), 16'd5);
    chk("t4b_port_latch", tr[1], 16'h7142);
    chk("t4b_gap", tr[2], 16'h3142);
    chk("t4b_strobe", tr[3], 16'h2377);
    chk("t4b_hold", tr[4], 16'h3377);
    do_req(1'b0, 2'd0, 1'b0, 16'h1238, 8'h00, 1'b0, 0, -1);
    chk("t4c_cache_kept", 16'(n), 16'd5);

    // T5: WAIT_STATES=2 with READY low for three sampled cycles, then a READY timeout
    bus_in = 8'h66;
    do_req(1'b1, 2'd0, 1'b0, 16'h2000, 8'h00, 1'b0, 7, 9);
    chk("t5a_latency", 16'(n), 16'd12);
    chk("t5a_oe_low", 16'(count_bit(13, 1'b0)), 16'd6);
    chk("t5a_rdata", {8'h0, got_rdata}, 16'h0066);
    chk("t5a_err", {15'h0, got_err}, 16'h0000);
    do_req(1'b1, 2'd0, 1'b0, 16'h3001, 8'h00, 1'b0, 1, 47);
    chk("t5b_latency", 16'(n), 16'd13);
    chk("t5b_oe_low", 16'(count_bit(13, 1'b0)), 16'd7);
    chk("t5b_err", {15'h0, got_err}, 16'h0001);
    chk("t5b_rdata_zero", {8'h0, got_rdata}, 16'h0000);
    do_req(1'b1, 2'd0, 1'b0, 16'h3002, 8'h00, 1'b0, 0, -1);
    chk("t5c_latency", 16'(n), 16'd9);
    chk("t5c_hi_after_timeout", tr[1], 16'hB130);

    // T6: asynchronous reset in the middle of a MEM write strobe
    req_type = 2'd0; req_we = 1'b1; req_addr = 16'h5678; req_wdata = 8'hEE; rv_a = 1'b1;
    tick();
    rv_a = 1'b0;
    repeat (4) tick();
    chk("t6_strobe_before", vec_a, 16'h21EE);
    rst = 1'b1;
    #1;
    chk("t6_async_release", vec_a, 16'h3000);
    chk("t6_req_ready_in_rst", {15'h0, rr_a}, 16'h0000);
    #1;
    rst = 1'b0;
    rsp_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      if (rsp_valid_a === 1'b1) rsp_cnt++;
      tick();
    end
    chk("t6_no_rsp", 16'(rsp_cnt), 16'd0);
    do_req(1'b0, 2'd0, 1'b0, 16'h5679, 8'h00, 1'b0, 0, -1);
    chk("t6_latency", 16'(n), 16'd7);
    chk("t6_hi_redone", tr[1], 16'hB156);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
